// File: rtl/dino_game_ctrl.sv
// Frame-rate game sequencer for the T-rex runner: game state, button edges, BCD score and speed.
// Optional feature macro: DINO_HISCORE_EN builds the high-score register; otherwise hiscore_o reads zero.
module dino_game_ctrl #(
  parameter int unsigned SPEED_INIT = 2,
  parameter int unsigned SPEED_MAX  = 8,
  parameter int unsigned SCORE_STEP = 6,
  parameter int unsigned DEAD_HOLD  = 60
) (
  input  logic        refreshclk,
  input  logic        rst,
  input  logic        start_btn_i,
  input  logic        jump_btn_i,
  input  logic        duck_btn_i,
  input  logic        collide_i,
  output logic [1:0]  gamestate_o,
  output logic        jump_o,
  output logic        lying_o,
  output logic [15:0] score_o,
  output logic [15:0] hiscore_o,
  output logic [3:0]  speed_o
);

  localparam int unsigned DIV_W  = (SCORE_STEP > 1) ? $clog2(SCORE_STEP) : 1;
  localparam int unsigned HOLD_W = (DEAD_HOLD > 1) ? $clog2(DEAD_HOLD) : 1;

  // state | meaning
  // IDLE  | waiting for the first go event, collide ignored
  // RUN   | scoring, jump/duck active
  // DEAD  | frozen display, hold-off before restart
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DEAD = 2'b10
  } state_e;

  state_e            state_q;
  logic              start_prev_q;
  logic              jump_prev_q;
  logic              jump_q;
  logic              lying_q;
  logic [15:0]       score_q;
  logic [3:0]        speed_q;
  logic [DIV_W-1:0]  div_q;
  logic [HOLD_W-1:0] hold_q;

  logic              start_rise;
  logic              jump_rise;
  logic              go;
  logic              score_tick;
  logic              score_sat;
  logic              speed_bump;
  logic [15:0]       score_inc_d;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    start_rise  = start_btn_i & ~start_prev_q;
    jump_rise   = jump_btn_i & ~jump_prev_q;
    go          = start_rise | jump_rise;
    score_tick  = (div_q == DIV_W'(SCORE_STEP - 1));
    score_sat   = (score_q == 16'h9999);
    score_inc_d = bcd_inc(score_q);
    // a fresh multiple of 100 bumps the scroll speed
    speed_bump  = ~score_sat & (score_inc_d[7:0] == 8'h00);
  end

  always_ff @(posedge refreshclk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      start_prev_q <= 1'b1;
      jump_prev_q  <= 1'b1;
      jump_q       <= 1'b0;
      lying_q      <= 1'b0;
      score_q      <= 16'h0000;
      speed_q      <= 4'(SPEED_INIT);
      div_q        <= '0;
      hold_q       <= '0;
    end else begin
      start_prev_q <= start_btn_i;
      jump_prev_q  <= jump_btn_i;
      jump_q       <= 1'b0;
      lying_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            state_q <= ST_RUN;
            score_q <= 16'h0000;
            speed_q <= 4'(SPEED_INIT);
            div_q   <= '0;
          end
        end
        ST_RUN: begin
          if (collide_i) begin
            state_q <= ST_DEAD;
            hold_q  <= HOLD_W'(DEAD_HOLD - 1);
          end else begin
            jump_q  <= jump_rise & ~duck_btn_i;
            lying_q <= duck_btn_i;
            if (score_tick) begin
              div_q <= '0;
              if (!score_sat) score_q <= score_inc_d;
              if (speed_bump && (speed_q < 4'(SPEED_MAX))) speed_q <= speed_q + 4'd1;
            end else begin
              div_q <= div_q + DIV_W'(1);
            end
          end
        end
        ST_DEAD: begin
          if (hold_q != '0) begin
            hold_q <= hold_q - HOLD_W'(1);
          end else if (go) begin
            state_q <= ST_RUN;
            score_q <= 16'h0000;
            speed_q <= 4'(SPEED_INIT);
            div_q   <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef DINO_HISCORE_EN
  logic [15:0] hiscore_q;

  // BCD digit order matches binary order, so a plain compare suffices
  always_ff @(posedge refreshclk or posedge rst) begin
    if (rst) begin
      hiscore_q <= 16'h0000;
    end else if ((state_q == ST_RUN) && collide_i && (score_q > hiscore_q)) begin
      hiscore_q <= score_q;
    end
  end

  assign hiscore_o = hiscore_q;
`else
  assign hiscore_o = 16'h0000;
`endif

  assign gamestate_o = state_q;
  assign jump_o      = jump_q;
  assign lying_o     = lying_q;
  assign score_o     = score_q;
  assign speed_o     = speed_q;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Directed self-checking bench for dino_game_ctrl with default parameters.
module tb_dino_game_ctrl;

  logic        refreshclk;
  logic        rst;
  logic        start_btn;
  logic        jump_btn;
  logic        duck_btn;
  logic        collide;
  logic [1:0]  gamestate;
  logic        jump;
  logic        lying;
  logic [15:0] score;
  logic [15:0] hiscore;
  logic [3:0]  speed;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DINO_HISCORE_EN
  localparam logic [15:0] HI_42   = 16'h0042;
  localparam logic [15:0] HI_9999 = 16'h9999;
`else
  localparam logic [15:0] HI_42   = 16'h0000;
  localparam logic [15:0] HI_9999 = 16'h0000;
`endif

  dino_game_ctrl dut (
    .refreshclk  (refreshclk),
    .rst         (rst),
    .start_btn_i (start_btn),
    .jump_btn_i  (jump_btn),
    .duck_btn_i  (duck_btn),
    .collide_i   (collide),
    .gamestate_o (gamestate),
    .jump_o      (jump),
    .lying_o     (lying),
    .score_o     (score),
    .hiscore_o   (hiscore),
    .speed_o     (speed)
  );

  initial begin
    refreshclk = 1'b0;
    forever #5 refreshclk = ~refreshclk;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge refreshclk);
  endtask

  task automatic test_reset;
    rst = 1'b1; start_btn = 1'b1; jump_btn = 1'b0; duck_btn = 1'b0; collide = 1'b0;
    tick(2);
    rst = 1'b0;
    n_checks++; if (gamestate !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b expected 00", gamestate); end
    n_checks++; if (score !== 16'h0000) begin n_fail++; $display("FAIL reset_score: got %h expected 0000", score); end
    n_checks++; if (hiscore !== 16'h0000) begin n_fail++; $display("FAIL reset_hiscore: got %h expected 0000", hiscore); end
    n_checks++; if (speed !== 4'd2) begin n_fail++; $display("FAIL reset_speed: got %0d expected 2", speed); end
    n_checks++; if (jump !== 1'b0 || lying !== 1'b0) begin n_fail++; $display("FAIL reset_jump_lying: got %b%b expected 00", jump, lying); end
    tick(10);
    n_checks++; if (gamestate !== 2'b00) begin n_fail++; $display("FAIL held_start_no_go: got %b expected 00", gamestate); end
    start_btn = 1'b0;
    tick(1);
    n_checks++; if (gamestate !== 2'b00) begin n_fail++; $display("FAIL release_no_go: got %b expected 00", gamestate); end
    start_btn = 1'b1;
    tick(1);
    n_checks++; if (gamestate !== 2'b01) begin n_fail++; $display("FAIL start_go: got %b expected 01", gamestate); end
    n_checks++; if (score !== 16'h0000 || speed !== 4'd2) begin n_fail++; $display("FAIL start_init: got score %h speed %0d expected 0000 2", score, speed); end
    start_btn = 1'b0;
  endtask

  task automatic test_jump;
    int cnt;
    cnt = 0;
    jump_btn = 1'b1;
    repeat (5) begin tick(1); if (jump === 1'b1) cnt++; end
    n_checks++; if (cnt !== 1) begin n_fail++; $display("FAIL jump_one_pulse: got %0d pulses expected 1", cnt); end
    jump_btn = 1'b0;
    tick(1);
    n_checks++; if (jump !== 1'b0) begin n_fail++; $display("FAIL jump_release: got %b expected 0", jump); end
    cnt = 0;
    jump_btn = 1'b1; duck_btn = 1'b1;
    repeat (5) begin
      tick(1);
      if (jump === 1'b1) cnt++;
      n_checks++; if (lying !== 1'b1) begin n_fail++; $display("FAIL duck_lying: got %b expected 1", lying); end
    end
    n_checks++; if (cnt !== 0) begin n_fail++; $display("FAIL duck_blocks_jump: got %0d pulses expected 0", cnt); end
    jump_btn = 1'b0; duck_btn = 1'b0;
    tick(1);
    n_checks++; if (lying !== 1'b0) begin n_fail++; $display("FAIL duck_release: got %b expected 0", lying); end
    n_checks++; if (score !== 16'h0002) begin n_fail++; $display("FAIL score_after_12: got %h expected 0002", score); end
  endtask

  task automatic test_collide_priority;
    tick(245);
    n_checks++; if (score !== 16'h0042) begin n_fail++; $display("FAIL score_42: got %h expected 0042", score); end
    collide = 1'b1; jump_btn = 1'b1;
    tick(1);
    collide = 1'b0; jump_btn = 1'b0;
    n_checks++; if (gamestate !== 2'b10) begin n_fail++; $display("FAIL collide_dead: got %b expected 10", gamestate); end
    n_checks++; if (score !== 16'h0042) begin n_fail++; $display("FAIL collide_drops_tick: got %h expected 0042", score); end
    n_checks++; if (hiscore !== HI_42) begin n_fail++; $display("FAIL collide_hiscore: got %h expected %h", hiscore, HI_42); end
    n_checks++; if (jump !== 1'b0) begin n_fail++; $display("FAIL collide_jump: got %b expected 0", jump); end
  endtask

  task automatic test_dead_holdoff;
    tick(58);
    start_btn = 1'b1;
    tick(1);
    start_btn = 1'b0;
    n_checks++; if (gamestate !== 2'b10) begin n_fail++; $display("FAIL holdoff_edge59: got %b expected 10", gamestate); end
    n_checks++; if (score !== 16'h0042) begin n_fail++; $display("FAIL dead_score_frozen: got %h expected 0042", score); end
    jump_btn = 1'b1;
    tick(1);
    jump_btn = 1'b0;
    n_checks++; if (gamestate !== 2'b01) begin n_fail++; $display("FAIL holdoff_edge60: got %b expected 01", gamestate); end
    n_checks++; if (score !== 16'h0000 || speed !== 4'd2) begin n_fail++; $display("FAIL restart_init: got score %h speed %0d expected 0000 2", score, speed); end
    n_checks++; if (hiscore !== HI_42) begin n_fail++; $display("FAIL restart_hiscore: got %h expected %h", hiscore, HI_42); end
    n_checks++; if (jump !== 1'b0) begin n_fail++; $display("FAIL go_no_jump: got %b expected 0", jump); end
  endtask

  task automatic test_lower_death;
    tick(180);
    n_checks++; if (score !== 16'h0030) begin n_fail++; $display("FAIL score_30: got %h expected 0030", score); end
    collide = 1'b1;
    tick(1);
    collide = 1'b0;
    n_checks++; if (gamestate !== 2'b10) begin n_fail++; $display("FAIL low_dead: got %b expected 10", gamestate); end
    n_checks++; if (hiscore !== HI_42) begin n_fail++; $display("FAIL hiscore_kept: got %h expected %h", hiscore, HI_42); end
    tick(59);
    start_btn = 1'b1;
    tick(1);
    start_btn = 1'b0;
    n_checks++; if (gamestate !== 2'b01) begin n_fail++; $display("FAIL restart2: got %b expected 01", gamestate); end
  endtask

  task automatic test_score_speed;
    tick(599);
    n_checks++; if (score !== 16'h0099 || speed !== 4'd2) begin n_fail++; $display("FAIL score_99: got %h speed %0d expected 0099 2", score, speed); end
    tick(1);
    n_checks++; if (score !== 16'h0100 || speed !== 4'd3) begin n_fail++; $display("FAIL score_100: got %h speed %0d expected 0100 3", score, speed); end
    tick((9999 - 100) * 6);
    n_checks++; if (score !== 16'h9999 || speed !== 4'd8) begin n_fail++; $display("FAIL score_9999: got %h speed %0d expected 9999 8", score, speed); end
    tick(6);
    n_checks++; if (score !== 16'h9999 || speed !== 4'd8) begin n_fail++; $display("FAIL score_saturate: got %h speed %0d expected 9999 8", score, speed); end
    collide = 1'b1;
    tick(1);
    collide = 1'b0;
    n_checks++; if (hiscore !== HI_9999) begin n_fail++; $display("FAIL hiscore_9999: got %h expected %h", hiscore, HI_9999); end
    tick(59);
    start_btn = 1'b1;
    tick(1);
    start_btn = 1'b0;
    n_checks++; if (gamestate !== 2'b01) begin n_fail++; $display("FAIL restart3: got %b expected 01", gamestate); end
  endtask

  task automatic test_async_reset;
    tick(738);
    n_checks++; if (score !== 16'h0123 || speed !== 4'd3) begin n_fail++; $display("FAIL score_123: got %h speed %0d expected 0123 3", score, speed); end
    duck_btn = 1'b1;
    tick(1);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (gamestate !== 2'b00) begin n_fail++; $display("FAIL async_state: got %b expected 00", gamestate); end
    n_checks++; if (score !== 16'h0000 || hiscore !== 16'h0000) begin n_fail++; $display("FAIL async_scores: got %h %h expected 0000 0000", score, hiscore); end
    n_checks++; if (speed !== 4'd2) begin n_fail++; $display("FAIL async_speed: got %0d expected 2", speed); end
    n_checks++; if (jump !== 1'b0 || lying !== 1'b0) begin n_fail++; $display("FAIL async_jump_lying: got %b%b expected 00", jump, lying); end
    duck_btn = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(2);
    n_checks++; if (gamestate !== 2'b00) begin n_fail++; $display("FAIL post_reset_idle: got %b expected 00", gamestate); end
  endtask

  initial begin
    rst = 1'b1; start_btn = 1'b0; jump_btn = 1'b0; duck_btn = 1'b0; collide = 1'b0;
    test_reset();
    test_jump();
    test_collide_priority();
    test_dead_holdoff();
    test_lower_death();
    test_score_speed();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
